// File: rtl/cmu_rr_arbiter.sv
// Round-robin share of one pipelined complex multiplier; product returns MUL_LATENCY+1 edges after grant, no stall.
// Optional CMU_ARB_STATS_EN adds saturating issue/conflict counters.
module cmu_rr_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int MUL_LATENCY = 3,
  parameter int ID_W        = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          arb_en,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ-1:0][31:0]      req_a,
  input  logic [NUM_REQ-1:0][31:0]      req_b,
  output logic [31:0]                   mul_a,
  output logic [31:0]                   mul_b,
  input  logic [31:0]                   mul_result,
  output logic                          rsp_valid,
  output logic [ID_W-1:0]               rsp_id,
  output logic [31:0]                   rsp_data,
  output logic                          idle
`ifdef CMU_ARB_STATS_EN
  ,
  output logic [31:0]                   stat_issued,
  output logic [31:0]                   stat_conflict
`endif
);

  logic [ID_W-1:0]  ptr_q, ptr_d;
  logic [ID_W:0]    scan_idx;
  logic [ID_W-1:0]  scan_id;
  logic [ID_W-1:0]  gnt_idx;
  logic             gnt_found;
  logic [NUM_REQ-1:0] gnt_oh;
  logic             xfer;

  logic [31:0]      mul_a_q, mul_a_d, mul_b_q, mul_b_d;
  logic [MUL_LATENCY:0] tag_vld_q;
  logic [ID_W-1:0]  tag_id_q [MUL_LATENCY+1];
  logic             rsp_valid_q;
  logic [ID_W-1:0]  rsp_id_q;

  // Scan from the pointer with wraparound; first valid requester wins.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    scan_idx  = '0;
    scan_id   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_idx = {1'b0, ptr_q} + (ID_W+1)'(k);
      if (scan_idx >= (ID_W+1)'(NUM_REQ))
        scan_idx = scan_idx - (ID_W+1)'(NUM_REQ);
      scan_id = scan_idx[ID_W-1:0];
      if (!gnt_found && req_valid[scan_id]) begin
        gnt_found = 1'b1;
        gnt_idx   = scan_id;
      end
    end
  end

  always_comb begin
    gnt_oh = '0;
    if (arb_en && rst_n && gnt_found)
      gnt_oh[gnt_idx] = 1'b1;
  end

  assign req_ready = gnt_oh;
  assign xfer      = |(req_valid & gnt_oh);

  always_comb begin
    ptr_d   = ptr_q;
    mul_a_d = '0;
    mul_b_d = '0;
    if (xfer) begin
      ptr_d   = (gnt_idx == ID_W'(NUM_REQ-1)) ? '0 : gnt_idx + ID_W'(1);
      mul_a_d = req_a[gnt_idx];
      mul_b_d = req_b[gnt_idx];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q   <= '0;
      mul_a_q <= '0;
      mul_b_q <= '0;
    end else begin
      ptr_q   <= ptr_d;
      mul_a_q <= mul_a_d;
      mul_b_q <= mul_b_d;
    end
  end

  // Tag line tracks the operand register plus the multiplier stages; the rsp register lines up with its result register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_vld_q   <= '0;
      for (int s = 0; s <= MUL_LATENCY; s++)
        tag_id_q[s] <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
    end else begin
      tag_vld_q   <= {tag_vld_q[MUL_LATENCY-1:0], xfer};
      tag_id_q[0] <= xfer ? gnt_idx : '0;
      for (int s = 1; s <= MUL_LATENCY; s++)
        tag_id_q[s] <= tag_id_q[s-1];
      rsp_valid_q <= tag_vld_q[MUL_LATENCY];
      rsp_id_q    <= tag_id_q[MUL_LATENCY];
    end
  end

  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_data  = rsp_valid_q ? mul_result : '0;
  assign idle      = ~xfer & ~(|tag_vld_q);

`ifdef CMU_ARB_STATS_EN
  logic [31:0] stat_issued_q, stat_conflict_q;
  logic        conflict;

  // Two or more bits set iff clearing the lowest set bit leaves something.
  assign conflict = arb_en & (|(req_valid & (req_valid - NUM_REQ'(1))));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_issued_q   <= '0;
      stat_conflict_q <= '0;
    end else begin
      if (xfer && (stat_issued_q != 32'hFFFF_FFFF))
        stat_issued_q <= stat_issued_q + 32'd1;
      if (conflict && (stat_conflict_q != 32'hFFFF_FFFF))
        stat_conflict_q <= stat_conflict_q + 32'd1;
    end
  end

  assign stat_issued   = stat_issued_q;
  assign stat_conflict = stat_conflict_q;
`endif

endmodule
